// File: rtl/imem_loader.sv
// imem_loader -- boot-time instruction-memory writer.
//
// Takes a byte stream (valid/ready), reads a 16-bit little-endian word count,
// then assembles count little-endian 32-bit words and writes each one to
// instruction memory at ADDR_BASE + 4*index. The processor is held in reset
// until the whole image has been written.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_rx_valid/i_rx_data/o_rx_ready   byte stream handshake
//   i_reload            restart loading (only honoured in DONE or ERR)
//   o_imem_we/o_imem_addr/o_imem_wdata  instruction-memory write port
//   o_cpu_reset         processor reset, low only in DONE
//   o_done, o_err       image complete / word count too large
//   o_led               {err, done, busy, heartbeat}
module imem_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  input  logic        i_reload,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_cpu_reset,
  output logic        o_done,
  output logic        o_err,
  output logic [3:0]  o_led
);

  typedef enum logic [2:0] {
    S_LEN0, S_LEN1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      r_state;
  logic [15:0] r_count;
  logic [15:0] r_index;
  logic [1:0]  r_byte_sel;
  logic [31:0] r_wdata;
  logic        r_hb;       // bit 0 of the accepted-byte counter

  logic        w_xfer;
  logic [15:0] w_cnt;      // full count as it stands when the LEN1 byte lands
  logic [15:0] w_index_nx;

  // Every output is a decode of registered state, so rx_valid never reaches
  // an output combinationally.
  assign o_rx_ready   = (r_state == S_LEN0) || (r_state == S_LEN1) || (r_state == S_DATA);
  assign o_imem_we    = (r_state == S_WRITE);
  assign o_imem_addr  = ADDR_BASE + {14'd0, r_index, 2'b00};
  assign o_imem_wdata = r_wdata;
  assign o_cpu_reset  = (r_state != S_DONE);
  assign o_done       = (r_state == S_DONE);
  assign o_err        = (r_state == S_ERR);
  assign o_led        = {o_err, o_done, !(o_done || o_err), r_hb};

  assign w_xfer     = i_rx_valid && o_rx_ready;
  assign w_cnt      = {i_rx_data, r_count[7:0]};
  assign w_index_nx = r_index + 16'd1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_LEN0;
      r_count    <= '0;
      r_index    <= '0;
      r_byte_sel <= '0;
      r_wdata    <= '0;
      r_hb       <= 1'b0;
    end else begin
      if (w_xfer) r_hb <= !r_hb;
      case (r_state)
        S_LEN0: if (w_xfer) begin
          r_count[7:0] <= i_rx_data;
          r_state      <= S_LEN1;
        end
        S_LEN1: if (w_xfer) begin
          r_count[15:8] <= i_rx_data;
          if (w_cnt == 16'd0)                    r_state <= S_DONE;
          else if ({16'd0, w_cnt} > MAX_WORDS)   r_state <= S_ERR;
          else begin
            r_index    <= '0;
            r_byte_sel <= '0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: if (w_xfer) begin
          r_wdata[{r_byte_sel, 3'b000} +: 8] <= i_rx_data;
          r_byte_sel <= r_byte_sel + 2'd1;
          if (r_byte_sel == 2'd3) r_state <= S_WRITE;
        end
        // One-cycle write; the address uses the pre-increment index.
        S_WRITE: begin
          r_index <= w_index_nx;
          r_state <= (w_index_nx == r_count) ? S_DONE : S_DATA;
        end
        S_DONE, S_ERR: if (i_reload) begin
          r_index <= '0;
          r_hb    <= 1'b0;
          r_state <= S_LEN0;
        end
        default: r_state <= S_LEN0;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a cycle table for the basic load / zero-length /
// over-length flows, hand sequences for reset corner cases, then randomized
// throttled images checked against a stream-level reference model. Two
// instances (base 0 and base 0x1000) share the same stimulus.
module tb_imem_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [63:0] wq_t[$];

  typedef struct {
    logic        rst, vld;
    logic [7:0]  d;
    logic        rld;
    logic        e_rdy, e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_cpu, e_done, e_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rx_valid = 1'b0, reload = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        rdy0, we0, cpu0, done0, err0;
  logic [31:0] addr0, wd0;
  logic [3:0]  led0;
  logic        rdy1, we1, cpu1, done1, err1;
  logic [31:0] addr1, wd1;
  logic [3:0]  led1;

  int checks = 0, failures = 0;
  int xfers = 0, cpu_bad = 0;
  wq_t q0, q1;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_BASE(32'h0000_0000), .MAX_WORDS(256)) u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_rx_ready(rdy0), .i_reload(reload), .o_imem_we(we0), .o_imem_addr(addr0),
    .o_imem_wdata(wd0), .o_cpu_reset(cpu0), .o_done(done0), .o_err(err0), .o_led(led0));

  imem_loader #(.ADDR_BASE(32'h0000_1000), .MAX_WORDS(256)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
    .o_rx_ready(rdy1), .i_reload(reload), .o_imem_we(we1), .o_imem_addr(addr1),
    .o_imem_wdata(wd1), .o_cpu_reset(cpu1), .o_done(done1), .o_err(err1), .o_led(led1));

  // Observe writes, transfers and the "processor never runs early" rule.
  always @(negedge clk) begin
    if (we0) q0.push_back({addr0, wd0});
    if (we1) q1.push_back({addr1, wd1});
    if (!rst && rx_valid && rdy0) xfers++;
    if (!cpu0 && !done0) cpu_bad++;
    if (!cpu1 && !done1) cpu_bad++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rs, vl, input logic [7:0] d, input logic rl,
                             input logic rdy, we, input logic [31:0] a, wd,
                             input logic cpu, dn, er);
    vec_t t;
    t.rst = rs; t.vld = vl; t.d = d; t.rld = rl; t.e_rdy = rdy; t.e_we = we;
    t.e_addr = a; t.e_wd = wd; t.e_cpu = cpu; t.e_done = dn; t.e_err = er;
    return t;
  endfunction

  // Reference model: what the stream means, independent of any FSM.
  function automatic void model(input bq_t b, input logic [31:0] base,
                                output wq_t w, output bit e);
    int cnt;
    cnt = int'(b[0]) + 256 * int'(b[1]);
    w = {};
    e = (cnt > 256);
    if (!e)
      for (int k = 0; k < cnt; k++)
        w.push_back({base + 32'(4 * k),
                     b[2+4*k+3], b[2+4*k+2], b[2+4*k+1], b[2+4*k]});
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input bq_t b, input bit thr);
    for (int i = 0; i < b.size(); i++) begin
      bit acc = 1'b0;
      int guard = 0;
      while (!acc) begin
        rx_valid = thr ? 1'($urandom_range(0, 1)) : 1'b1;
        rx_data  = rx_valid ? b[i] : 8'($urandom);
        @(negedge clk);
        acc = rx_valid && rdy0;
        step();
        guard++;
        if (!acc && guard > 100) begin
          chk("send_timeout", 64'(i), 64'(b.size()));
          rx_valid = 1'b0;
          return;
        end
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic wait_end(input string nm);
    bit seen = 1'b0;
    for (int g = 0; g < 60 && !seen; g++) begin
      @(negedge clk);
      seen = done0 || err0;
    end
    if (!seen) chk({nm, "_end_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  task automatic run_image(input string nm, input bq_t b, input bit thr);
    wq_t w0, w1;
    bit  e;
    int  x0;
    model(b, 32'h0000_0000, w0, e);
    model(b, 32'h0000_1000, w1, e);
    q0 = {}; q1 = {};
    x0 = xfers;
    send(b, thr);
    wait_end(nm);
    chk({nm, "_nwr0"}, 64'(q0.size()), 64'(w0.size()));
    chk({nm, "_nwr1"}, 64'(q1.size()), 64'(w1.size()));
    for (int i = 0; i < w0.size() && i < q0.size(); i++) chk({nm, "_wr0"}, q0[i], w0[i]);
    for (int i = 0; i < w1.size() && i < q1.size(); i++) chk({nm, "_wr1"}, q1[i], w1[i]);
    chk({nm, "_xfers"}, 64'(xfers - x0), 64'(b.size()));
    chk({nm, "_flags"}, {60'd0, cpu0, done0, err0, rdy0}, {60'd0, e, !e, e, 1'b0});
    step();
    pulse_reload();
    @(negedge clk);
    chk({nm, "_reload"}, {60'd0, cpu0, done0, err0, rdy0}, 64'b1001);
    step();
  endtask

  initial begin
    vec_t tv[$];
    bq_t  b;

    // Reset state
    rst = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_led", 64'(led0), 64'b0010);
    chk("rst_flags", {60'd0, rdy0, we0, cpu0, done0}, 64'b1010);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_wd", 64'(wd0), 64'd0);
    chk("rst_addr0", 64'(addr0), 64'h0);
    chk("rst_addr1", 64'(addr1), 64'h1000);
    step();
    rst = 1'b0;

    // Cycle table: each row's expectations are the outputs of the cycle in
    // which its inputs are presented.
    tv.push_back(v(0,1,8'h02,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,1,8'h00,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,1,8'h78,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,1,8'h56,1, 1,0,0,0, 1,0,0));   // reload ignored in DATA
    tv.push_back(v(0,1,8'h34,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,1,8'h12,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,0,8'h00,0, 0,1,32'h0,32'h12345678, 1,0,0));
    tv.push_back(v(0,1,8'hEF,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,1,8'hBE,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,1,8'hAD,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,1,8'hDE,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,1,8'h55,0, 0,1,32'h4,32'hDEADBEEF, 1,0,0)); // valid in WRITE
    tv.push_back(v(0,0,8'h00,0, 0,0,0,0, 0,1,0));
    tv.push_back(v(0,0,8'h00,1, 0,0,0,0, 0,1,0));
    tv.push_back(v(0,0,8'h00,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,1,8'h00,0, 1,0,0,0, 1,0,0));   // zero-length image
    tv.push_back(v(0,1,8'h00,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,0,8'h00,0, 0,0,0,0, 0,1,0));
    tv.push_back(v(0,0,8'h00,1, 0,0,0,0, 0,1,0));
    tv.push_back(v(0,1,8'h01,0, 1,0,0,0, 1,0,0));   // count = 257
    tv.push_back(v(0,1,8'h01,0, 1,0,0,0, 1,0,0));
    tv.push_back(v(0,1,8'hAA,0, 0,0,0,0, 1,0,1));
    tv.push_back(v(0,0,8'h00,1, 0,0,0,0, 1,0,1));
    tv.push_back(v(0,0,8'h00,0, 1,0,0,0, 1,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; rx_valid = tv[i].vld; rx_data = tv[i].d; reload = tv[i].rld;
      @(negedge clk);
      chk($sformatf("tv%0d_ctl", i), {59'd0, rdy0, we0, cpu0, done0, err0},
          {59'd0, tv[i].e_rdy, tv[i].e_we, tv[i].e_cpu, tv[i].e_done, tv[i].e_err});
      chk($sformatf("tv%0d_led", i), 64'(led0[3:1]),
          {61'd0, tv[i].e_err, tv[i].e_done, !(tv[i].e_done || tv[i].e_err)});
      if (tv[i].e_we) begin
        chk($sformatf("tv%0d_wr0", i), {addr0, wd0}, {tv[i].e_addr, tv[i].e_wd});
        chk($sformatf("tv%0d_wr1", i), {addr1, wd1}, {tv[i].e_addr + 32'h1000, tv[i].e_wd});
      end
      step();
    end
    rx_valid = 1'b0; reload = 1'b0;

    // Over-length image then a valid one after reload
    run_image("over", '{8'h01, 8'h01}, 1'b0);
    run_image("after_err", '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD}, 1'b0);

    // Reset mid-word discards the partial word
    q0 = {};
    send('{8'h01, 8'h00, 8'h11, 8'h22}, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midword_state", {59'd0, rdy0, we0, cpu0, done0, err0}, 64'b10100);
    chk("midword_led", 64'(led0), 64'b0010);
    chk("midword_nwr", 64'(q0.size()), 64'd0);
    step();
    run_image("post_rst", '{8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11}, 1'b0);

    // Reset during the WRITE cycle
    send('{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04}, 1'b0);
    @(negedge clk);
    chk("wr_rst_we", 64'(we0), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("wr_rst_state", {59'd0, rdy0, we0, cpu0, done0, err0}, 64'b10100);
    step();
    run_image("zero_after_rst", '{8'h00, 8'h00}, 1'b1);

    // Throttled basic image, then two one-word loads across a reload
    run_image("throttled", '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                             8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b1);
    run_image("one_a", '{8'h01, 8'h00, 8'h0D, 8'hF0, 8'hAD, 8'h8B}, 1'b0);
    run_image("one_b", '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 1'b1);

    // Largest accepted image
    b = '{8'h00, 8'h01};
    for (int i = 0; i < 1024; i++) b.push_back(8'($urandom));
    run_image("max256", b, 1'b0);

    // Random images
    for (int n = 0; n < 12; n++) begin
      int sel, cnt;
      sel = $urandom_range(0, 9);
      cnt = (sel == 0) ? 0 : (sel == 1) ? 257 + $urandom_range(0, 4000) : $urandom_range(1, 6);
      b = '{8'(cnt), 8'(cnt >> 8)};
      if (cnt <= 256)
        for (int i = 0; i < 4 * cnt; i++) b.push_back(8'($urandom));
      run_image($sformatf("rand%0d", n), b, 1'b1);
    end

    chk("cpu_run_early", 64'(cpu_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
